// File: rtl/team_06_delay_line_ctrl.sv
// team_06_delay_line_ctrl
// Per-sample sequencer for the echo/reverb datapath and its delay-line SRAM.
// On each sample_tick it reads the delayed sample at (wr_ptr - offset) and
// presents it as past_output. It then writes save_audio back at wr_ptr and
// advances the pointer.
//
// Optional build macro: TEAM_06_DLY_TIMEOUT_EN
//   When defined, a watchdog abandons a request that is not acked within
//   TIMEOUT_CYC cycles, and the sticky mem_timeout port is present.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   sample_tick       one-cycle pulse per audio sample
//   echo_en/reverb_en mode requests (both or neither -> bypass)
//   cfg_wr/cfg_sel/cfg_ofs  offset register write (sel 0 = echo, 1 = reverb)
//   save_audio        sample from the datapath to store
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  SRAM handshake
//   past_output       delayed sample (registered)
//   offset            active offset latched for the current sample
//   sample_valid      one-cycle pulse while in PROC
//   busy              high in any state other than IDLE
//   overrun           sticky; a tick arrived while busy
//   mem_timeout       (optional) sticky; a request was abandoned
module team_06_delay_line_ctrl #(
  parameter int unsigned          ADDR_W      = 13,
  parameter int unsigned          DATA_W      = 8,
  parameter logic [ADDR_W-1:0]    ECHO_OFS    = 13'd4000,
  parameter logic [ADDR_W-1:0]    REVERB_OFS  = 13'd800,
  parameter int unsigned          TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              echo_en,
  input  logic              reverb_en,
  input  logic              cfg_wr,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_ofs,
  input  logic [DATA_W-1:0] save_audio,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] past_output,
  output logic [ADDR_W-1:0] offset,
  output logic              sample_valid,
  output logic              busy,
`ifdef TEAM_06_DLY_TIMEOUT_EN
  output logic              mem_timeout,
`endif
  output logic              overrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_PROC,
    ST_WR
  } state_e;

  typedef enum logic [1:0] {
    MODE_BYPASS,
    MODE_ECHO,
    MODE_REVERB
  } mode_e;

  state_e            state_q, state_d;
  mode_e             mode_sel;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] echo_ofs_q;
  logic [ADDR_W-1:0] rev_ofs_q;
  logic [ADDR_W-1:0] ofs_q;
  logic [ADDR_W-1:0] sel_ofs;
  logic [DATA_W-1:0] past_q;
  logic [DATA_W-1:0] wdata_q;
  logic              overrun_q;
  logic              skip_rd;
  logic              wd_expire;

  // Mode and read-skip decision, evaluated against the live registers so the
  // value latched at the tick is what governs the whole sample.
  always_comb begin
    mode_sel = MODE_BYPASS;
    sel_ofs  = '0;
    if (echo_en && !reverb_en) begin
      mode_sel = MODE_ECHO;
      sel_ofs  = echo_ofs_q;
    end else if (reverb_en && !echo_en) begin
      mode_sel = MODE_REVERB;
      sel_ofs  = rev_ofs_q;
    end
    skip_rd = (mode_sel == MODE_BYPASS) || (sel_ofs == '0) || (fill_cnt < sel_ofs);
  end

`ifdef TEAM_06_DLY_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Counter restarts on every state change, so it measures time spent in
  // the current RD or WR request only.
  assign wd_expire = ((state_q == ST_RD) || (state_q == ST_WR)) && !mem_ack &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wd_cnt <= '0;
      end else if ((state_q == ST_RD) || (state_q == ST_WR)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    sample_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          state_d = skip_rd ? ST_PROC : ST_RD;
        end
      end
      ST_RD: begin
        mem_req  = 1'b1;
        mem_addr = wr_ptr - ofs_q;
        if (mem_ack || wd_expire) begin
          state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        sample_valid = 1'b1;
        state_d      = ST_WR;
      end
      ST_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wr_ptr;
        if (mem_ack || wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      echo_ofs_q <= ECHO_OFS;
      rev_ofs_q  <= REVERB_OFS;
      ofs_q      <= '0;
      past_q     <= '0;
      wdata_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (cfg_wr) begin
        if (cfg_sel) begin
          rev_ofs_q <= cfg_ofs;
        end else begin
          echo_ofs_q <= cfg_ofs;
        end
      end

      // Any tick seen outside IDLE is lost, including one coincident with
      // the WR ack (state is still WR on that edge).
      if (sample_tick && busy) begin
        overrun_q <= 1'b1;
      end

      if ((state_q == ST_IDLE) && sample_tick) begin
        ofs_q <= sel_ofs;
        if (skip_rd) begin
          past_q <= '0;
        end
      end

      if (state_q == ST_RD) begin
        if (mem_ack) begin
          past_q <= mem_rdata;
        end else if (wd_expire) begin
          past_q <= '0;
        end
      end

      if (state_q == ST_PROC) begin
        wdata_q <= save_audio;
      end

      if ((state_q == ST_WR) && (mem_ack || wd_expire)) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_cnt != '1) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end
  end

  assign past_output = past_q;
  assign offset      = ofs_q;
  assign mem_wdata   = wdata_q;
  assign overrun     = overrun_q;

endmodule
